// File: rtl/seq_det_pkg.sv
// Shared state encoding and default sizing for the serial pattern detector.
package seq_det_pkg;

  localparam int DEF_PAT_W = 3;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Config, bit-stream handshake and status bundle of the pattern detector.
// master = stream source / software side, slave = detector controller.
interface seq_det_ctrl_if #(
  parameter int PAT_W = seq_det_pkg::DEF_PAT_W,
  parameter int CNT_W = seq_det_pkg::DEF_CNT_W
);
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_thresh;
  logic             start;
  logic             stop;
  logic             din_valid;
  logic             din;
  logic             din_ready;
  logic             match;
  logic [CNT_W-1:0] det_count;
  logic             done;
  logic             busy;
  logic [1:0]       state_out;

  modport master (
    output cfg_we, cfg_pattern, cfg_thresh, start, stop, din_valid, din,
    input  din_ready, match, det_count, done, busy, state_out
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_thresh, start, stop, din_valid, din,
    output din_ready, match, det_count, done, busy, state_out
  );
endinterface

// File: rtl/seq_shift_match.sv
// Bit history shift register with fill tracking and pattern comparator.
// Latency: hit is combinational with the shifted bit; history updates next edge.
// Backpressure: none, shifts only when shift_en is asserted by the controller.
module seq_shift_match #(
  parameter int PAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             din,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);
  localparam int HW = PAT_W - 1;
  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] FULL = FW'(HW);

  logic [HW-1:0]    history;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] window;

  // Window is the pattern-length view including the bit being accepted now.
  assign window = {history, din};
  assign hit    = shift_en & (fill == FULL) & (window == pattern);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= '0;
      fill    <= '0;
    end else if (clr) begin
      history <= '0;
      fill    <= '0;
    end else if (shift_en) begin
      history <= window[HW-1:0];
      if (fill != FULL) fill <= fill + FW'(1);
    end
  end
endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for a serial pattern detector; SEQ_DET_NOOVERLAP_EN selects non-overlapping matching.
// Latency: match is same-cycle with the accepted bit; det_count/done update one edge later.
// Backpressure: din_ready is high only in RUN; HOLD and IDLE stall the stream.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  seq_det_ctrl_if.slave bus
);
`ifdef SEQ_DET_NOOVERLAP_EN
  localparam bit NOOVERLAP = 1'b1;
`else
  localparam bit NOOVERLAP = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] thresh;
  logic [CNT_W-1:0] det_count;
  logic [CNT_W-1:0] cnt_inc;
  logic             done;
  logic             in_run;
  logic             acc;
  logic             hit;
  logic             fresh;
  logic             thr_hit;
  logic             sm_clr;

  assign in_run  = (state == RUN);
  assign acc     = bus.din_valid & in_run;
  assign fresh   = bus.start & ~bus.stop & ((state == IDLE) | (state == HOLD));
  assign cnt_inc = det_count + CNT_W'(1);
  assign thr_hit = hit & (thresh != '0) & (cnt_inc == thresh);
  assign sm_clr  = fresh | (NOOVERLAP & hit);

  seq_shift_match #(.PAT_W(PAT_W)) u_match (
    .clk      (clk),
    .rst      (rst),
    .shift_en (acc),
    .clr      (sm_clr),
    .din      (bus.din),
    .pattern  (pattern),
    .hit      (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // stop outranks start and threshold everywhere.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.stop) state_nxt = IDLE;
            else if (bus.start) state_nxt = RUN;
      RUN:  if (bus.stop) state_nxt = IDLE;
            else if (thr_hit) state_nxt = HOLD;
      HOLD: if (bus.stop) state_nxt = IDLE;
            else if (bus.start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.din_ready = in_run;
    bus.busy      = in_run;
    bus.match     = hit;
    bus.det_count = det_count;
    bus.done      = done;
    bus.state_out = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern <= '0;
      thresh  <= '0;
    end else if (bus.cfg_we && state == IDLE) begin
      pattern <= bus.cfg_pattern;
      thresh  <= bus.cfg_thresh;
    end
  end

  // A bit accepted on the stop cycle still counts; the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_count <= '0;
      done      <= 1'b0;
    end else begin
      if (fresh) det_count <= '0;
      else if (hit && det_count != '1) det_count <= cnt_inc;

      if (fresh) done <= 1'b0;
      else if (bus.stop) done <= 1'b0;
      else if (in_run && thr_hit) done <= 1'b1;
    end
  end
endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Run controller for a programmable serial bit-pattern detector.
- Accepts a configurable pattern and match threshold, then arms on start.
- Streams bits in through a valid/ready handshake and counts overlapping pattern matches.
- Stops the stream and raises done when the threshold is reached.
- Sits between the bit-stream source and downstream software/status logic.

Parameters:
PAT_W, 3, pattern length in bits (>=2)
CNT_W, 8, width of the match counter and threshold

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_we  in  1  load cfg_pattern/cfg_thresh (honoured only in IDLE)
cfg_pattern  in  PAT_W  pattern, MSB is the oldest bit
cfg_thresh  in  CNT_W  match count that ends the run; 0 = unlimited
start  in  1  arm/re-arm run (1-cycle pulse)
stop  in  1  abort to IDLE (1-cycle pulse)
din_valid  in  1  serial bit valid
din  in  1  serial bit
din_ready  out  1  controller accepts a bit this cycle
match  out  1  Mealy match flag for the bit accepted this cycle
det_count  out  CNT_W  matches in current/last run
done  out  1  threshold reached
busy  out  1  state == RUN
state_out  out  2  present state, debug

Behaviour:
- Reset rst is asynchronous, active-high; clock is clk.
- Reset values: state=IDLE, pattern=0, thresh=0, history=0, fill=0, det_count=0, all outputs 0.
- States: IDLE=2'b00, RUN=2'b01, HOLD=2'b10. Encoding 2'b11 is illegal and recovers to IDLE next cycle.
- Accept event: acc = din_valid & din_ready.
- din_ready = (state==RUN), combinational.
- IDLE:
  - cfg_we registers pattern and thresh.
  - start -> RUN. On the same edge: clear det_count, history, fill and done.
- RUN:
  - Each acc shifts din into history (PAT_W-1 bits).
  - fill increments on each acc, saturating at PAT_W-1.
  - match = acc & (fill==PAT_W-1) & ({history,din}==pattern). Combinational, same cycle as the bit.
  - Detection is overlapping; history is not cleared on a match.
  - On match, det_count increments on the next edge. It saturates at all-ones and never wraps.
  - If thresh!=0 and match and det_count+1==thresh: -> HOLD, done<=1.
- HOLD:
  - din_ready=0; done held and det_count frozen.
  - start -> RUN (fresh run, clears as in IDLE).
  - stop -> IDLE, done cleared.
- stop in RUN -> IDLE. det_count is retained; done stays 0. A bit accepted on the stop cycle is still evaluated and counted.
- Simultaneous start and stop: stop wins.
- start while in RUN: ignored.
- cfg_we outside IDLE: ignored.
- thresh=0: run continues until stop; det_count saturates.
- Mid-operation reset: immediate return to reset values; the partial run is lost.
- Latency: match is 0 cycles from the accepting bit; det_count/done update 1 cycle later.

Optional Feature:
SEQ_DET_NOOVERLAP_EN
- Defined: non-overlapping detection. On a match, fill and history are cleared, so the next match needs PAT_W fresh bits.
- Undefined: overlapping detection as above.

Decomposition:
- Package seq_det_pkg: state encoding constants (IDLE, RUN, HOLD), state typedef, default PAT_W/CNT_W constants.
- One sub-module, seq_shift_match. It holds the history shift register, fill counter and pattern comparator, with inputs shift_en, clr, din, pattern and output hit.
- Controller FSM, counter and threshold logic stay in seq_det_ctrl.

Test Plan:
- Pattern 3'b101, thresh 2, start, stream 1,0,1,0,1 with din_valid=1 -> match on bits 3 and 5; det_count=2; done=1 the cycle after bit 5; din_ready=0 thereafter.
- Same stream with SEQ_DET_NOOVERLAP_EN -> match only on bit 3. Then stream 1,0,1,1,0,1 -> matches on bits 3 and 6.
- RUN with din_valid gaps (1,-,0,-,-,1) -> a single match on the third valid bit; invalid cycles never shift history.
- cfg_we with pattern 3'b111 during RUN -> ignored: stream 1,1,1 gives no match against 3'b101. After stop, cfg_we then start -> 1,1,1,1 matches on bits 3 and 4.
- CNT_W=2, thresh 0, pattern 2'b11, stream of eight 1s -> det_count saturates at 3, never HOLD. start+stop in the same cycle -> IDLE.
- Assert rst mid-run after 2 matches -> asynchronously state=IDLE, det_count=0, done=0, din_ready=0. A start after release begins a clean run.
